// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered multi-lane I/S/B/U/J(/Z) immediate generator sitting
// on the decode->execute boundary, with a valid/ready handshake, a one-entry
// skid register behind the output register, and a pipeline flush.
// Optional feature macro: IMM_ZICSR_EN (sel=5 yields the zero-extended CSR uimm).
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES-1:0]        in_lane_vld_i,
  input  logic [3*LANES-1:0]      in_sel_i,
  input  logic [32*LANES-1:0]     in_instr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES-1:0]        out_lane_vld_o,
  output logic [XLEN*LANES-1:0]   out_imm_o
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned INS_W = 32;
  localparam int unsigned IMM_W = XLEN * LANES;

  localparam logic [SEL_W-1:0] SEL_I = 3'd0;
  localparam logic [SEL_W-1:0] SEL_S = 3'd1;
  localparam logic [SEL_W-1:0] SEL_B = 3'd2;
  localparam logic [SEL_W-1:0] SEL_U = 3'd3;
  localparam logic [SEL_W-1:0] SEL_J = 3'd4;
`ifdef IMM_ZICSR_EN
  localparam logic [SEL_W-1:0] SEL_Z = 3'd5;
`endif

  // Decode one instruction; every signed format is built at 32 bits, then sign-extended
  function automatic logic [XLEN-1:0] decode(input logic [SEL_W-1:0] sel,
                                             input logic [INS_W-1:0] ins);
    logic [INS_W-1:0] imm32;
    logic [XLEN-1:0]  res;
    imm32 = '0;
    case (sel)
      SEL_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      SEL_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      SEL_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SEL_U:   imm32 = {ins[31:12], 12'b0};
      SEL_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    res = XLEN'($signed(imm32));
`ifdef IMM_ZICSR_EN
    if (sel == SEL_Z) res = XLEN'(ins[19:15]);
`endif
    return res;
  endfunction

  logic [IMM_W-1:0] dec_imm;
  logic [IMM_W-1:0] skid_imm;
  logic [LANES-1:0] skid_lane_vld;
  logic             skid_valid;
  logic             accept;
  logic             out_free;
  logic             unused_opcode_bits;

  // Opcode bits [6:0] carry no immediate information
  assign unused_opcode_bits = ^in_instr_i;

  assign accept   = in_valid_i & in_ready_o;
  assign out_free = ~out_valid_o | out_ready_i;

  // Per-lane decode; invalid lanes contribute a zero immediate
  always_comb begin
    dec_imm = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (in_lane_vld_i[k])
        dec_imm[XLEN*k +: XLEN] = decode(in_sel_i[SEL_W*k +: SEL_W], in_instr_i[INS_W*k +: INS_W]);
    end
  end

  // Output register + skid register; flush beats accept/drain, in_ready tracks skid emptiness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o    <= 1'b0;
      out_lane_vld_o <= '0;
      out_imm_o      <= '0;
      skid_valid     <= 1'b0;
      skid_lane_vld  <= '0;
      skid_imm       <= '0;
      in_ready_o     <= 1'b1;
    end else if (flush_i) begin
      out_valid_o    <= 1'b0;
      out_lane_vld_o <= '0;
      skid_valid     <= 1'b0;
      in_ready_o     <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_o    <= 1'b1;
        out_lane_vld_o <= skid_lane_vld;
        out_imm_o      <= skid_imm;
      end else if (accept) begin
        out_valid_o    <= 1'b1;
        out_lane_vld_o <= in_lane_vld_i;
        out_imm_o      <= dec_imm;
      end else begin
        out_valid_o    <= 1'b0;
      end
      skid_valid <= 1'b0;
      in_ready_o <= 1'b1;
    end else if (accept) begin
      skid_valid    <= 1'b1;
      skid_lane_vld <= in_lane_vld_i;
      skid_imm      <= dec_imm;
      in_ready_o    <= 1'b0;
    end
  end

endmodule
